// File: rtl/div_ratio_detector.sv
// div_ratio_detector: measures period and high time of a slow 1-bit signal
// in clk cycles, flags a stable measurement (locked) and a missing edge
// (sticky overflow). Used as the self-test monitor for divide-by-N blocks.
module div_ratio_detector #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             overflow
);

  localparam int unsigned MATCH_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_COUNT);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  // Current state
  logic [0:0]         state;
  logic               sig_d;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   hi_cnt;
  logic [CNT_W-1:0]   ref_period;
  logic [CNT_W-1:0]   ref_high;
  logic [MATCH_W-1:0] match_cnt;
  logic               first_meas;

  // Next state
  logic [0:0]         state_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   hi_cnt_nxt;
  logic [CNT_W-1:0]   ref_period_nxt;
  logic [CNT_W-1:0]   ref_high_nxt;
  logic [MATCH_W-1:0] match_cnt_nxt;
  logic               first_meas_nxt;
  logic [CNT_W-1:0]   period_nxt;
  logic [CNT_W-1:0]   high_time_nxt;
  logic               valid_nxt;
  logic               locked_nxt;
  logic               overflow_nxt;

  logic               rise_c;
  logic               same_as_ref_c;
  logic [MATCH_W-1:0] match_inc_c;

  // Rising edge of the monitored signal and lock-compare helpers
  always_comb begin
    rise_c        = sig_in & ~sig_d;
    same_as_ref_c = (cnt == ref_period) && (hi_cnt == ref_high);
    match_inc_c   = (match_cnt == LOCK_TGT) ? match_cnt : match_cnt + MATCH_W'(1);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    hi_cnt_nxt     = hi_cnt;
    ref_period_nxt = ref_period;
    ref_high_nxt   = ref_high;
    match_cnt_nxt  = match_cnt;
    first_meas_nxt = first_meas;
    period_nxt     = period;
    high_time_nxt  = high_time;
    valid_nxt      = 1'b0;
    locked_nxt     = locked;
    overflow_nxt   = overflow;

    case (state)
      IDLE: begin
        // The edge cycle itself is the first high sample of the period
        if (rise_c) begin
          cnt_nxt        = CNT_ONE;
          hi_cnt_nxt     = CNT_ONE;
          first_meas_nxt = 1'b1;
          state_nxt      = MEASURE;
        end
      end

      MEASURE: begin
        if (rise_c) begin
          period_nxt    = cnt;
          high_time_nxt = hi_cnt;
          valid_nxt     = 1'b1;
          cnt_nxt       = CNT_ONE;
          hi_cnt_nxt    = CNT_ONE;
          if (first_meas) begin
            // First result after a restart is only a reference
            ref_period_nxt = cnt;
            ref_high_nxt   = hi_cnt;
            match_cnt_nxt  = '0;
            locked_nxt     = 1'b0;
            first_meas_nxt = 1'b0;
          end else if (same_as_ref_c) begin
            match_cnt_nxt = match_inc_c;
            locked_nxt    = (match_inc_c == LOCK_TGT);
          end else begin
            ref_period_nxt = cnt;
            ref_high_nxt   = hi_cnt;
            match_cnt_nxt  = '0;
            locked_nxt     = 1'b0;
          end
        end else if (cnt == CNT_MAX) begin
          // Period too long to represent: give up and wait for a fresh edge
          overflow_nxt  = 1'b1;
          locked_nxt    = 1'b0;
          match_cnt_nxt = '0;
          state_nxt     = IDLE;
        end else begin
          cnt_nxt    = cnt + CNT_ONE;
          hi_cnt_nxt = hi_cnt + CNT_W'(sig_in);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; rst and clr are equivalent synchronous clears
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state      <= IDLE;
      sig_d      <= 1'b1;
      cnt        <= '0;
      hi_cnt     <= '0;
      ref_period <= '0;
      ref_high   <= '0;
      match_cnt  <= '0;
      first_meas <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      sig_d      <= sig_in;
      cnt        <= cnt_nxt;
      hi_cnt     <= hi_cnt_nxt;
      ref_period <= ref_period_nxt;
      ref_high   <= ref_high_nxt;
      match_cnt  <= match_cnt_nxt;
      first_meas <= first_meas_nxt;
      period     <= period_nxt;
      high_time  <= high_time_nxt;
      valid      <= valid_nxt;
      locked     <= locked_nxt;
      overflow   <= overflow_nxt;
    end
  end

endmodule
